// File: rtl/div_unit.sv
// div_unit -- iterative radix-2 restoring divider (DIV / DIVU) for the
// execute stage. Returns {remainder, quotient} for the HI/LO write path.
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   start_i     divide request, held high until ready_o is seen
//   signed_i    1 = DIV (two's complement), 0 = DIVU; sampled with start_i
//   annul_i     pipeline flush, discards an in-flight divide
//   opa_i       dividend (rs); sampled with start_i
//   opb_i       divisor (rt); sampled with start_i
//   result_o    {remainder -> HI, quotient -> LO}, registered
//   ready_o     result valid, registered
//   busy_o      high while dividing (ZERO/ON); stall request to the hazard unit
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ZERO, S_ON, S_END} state_e;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic                 capture;
  logic                 abort;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [2*WIDTH:0]     shifted;
  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     quo_raw, rem_raw;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // annul_i outranks start_i everywhere; rst is handled in the register.
  assign capture = start_i && !annul_i;
  assign abort   = annul_i || !start_i;

  // Magnitudes of the operands; the signs are kept separately for the
  // final correction so the iteration itself is always unsigned.
  assign abs_a = (signed_i && opa_i[WIDTH-1]) ? -opa_i : opa_i;
  assign abs_b = (signed_i && opb_i[WIDTH-1]) ? -opb_i : opb_i;

  // One restoring step: shift the partial remainder left and try to take
  // the divisor off the top WIDTH+1 bits. A clear MSB in the trial means
  // the subtraction fits and the new quotient bit is 1.
  assign shifted = {rem_q[2*WIDTH-1:0], 1'b0};
  assign trial   = shifted[2*WIDTH:WIDTH] - {1'b0, dvs_q};

  // After WIDTH steps the quotient sits in the low half and the remainder
  // in the next WIDTH bits. Negating 0x80000000 wraps back to itself,
  // which is exactly the MIPS result for the most-negative / -1 case.
  assign quo_raw = rem_q[WIDTH-1:0];
  assign rem_raw = rem_q[2*WIDTH-1:WIDTH];
  assign quo_fix = neg_quo_q ? -quo_raw : quo_raw;
  assign rem_fix = neg_rem_q ? -rem_raw : rem_raw;

  // State register plus all datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (capture) state_d = (opb_i == '0) ? S_ZERO : S_ON;
      S_ZERO: state_d = abort ? S_IDLE : S_END;
      S_ON: begin
        if (abort)                   state_d = S_IDLE;
        else if (cnt_q == LAST_STEP) state_d = S_END;
      end
      S_END:  if (abort) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates. result_d and ready_d default to zero so that any
  // path back to IDLE clears them; only END holds them.
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = '0;
    ready_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (capture) begin
          cnt_d     = '0;
          rem_d     = {{(WIDTH+1){1'b0}}, abs_a};
          dvs_d     = abs_b;
          neg_quo_d = signed_i && (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
          neg_rem_d = signed_i && opa_i[WIDTH-1];
        end
      end
      S_ZERO: begin
        if (state_d == S_END) ready_d = 1'b1;
      end
      S_ON: begin
        if (state_d == S_ON) begin
          rem_d = shifted;
          if (!trial[WIDTH]) begin
            rem_d[2*WIDTH:WIDTH] = trial;
            rem_d[0]             = 1'b1;
          end
          cnt_d = cnt_q + 1'b1;
        end else if (state_d == S_END) begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
        end
      end
      S_END: begin
        if (state_d == S_END) begin
          result_d = result_q;
          ready_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs: busy is decoded from state, the rest are registered.
  always_comb begin
    busy_o   = (state_q == S_ZERO) || (state_q == S_ON);
    result_o = result_q;
    ready_o  = ready_q;
  end

endmodule
